// File: rtl/vga_pkg.sv
// Shared VGA geometry, coordinate widths and the position FSM encoding.
// Also holds the signed step selected by one pair of opposing keys.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int OBJ_W    = 32;
  localparam int OBJ_H    = 32;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int X_MAX    = H_ACTIVE - OBJ_W;
  localparam int Y_MAX    = V_ACTIVE - OBJ_H;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    UPD_X,
    UPD_Y
  } fsm_t;

  // Opposing keys cancel out.
  function automatic logic signed [4:0] axis_step(
    input logic       inc,
    input logic       dec,
    input logic [3:0] step
  );
    logic signed [4:0] s;
    s = signed'({1'b0, step});
    if (inc && !dec)
      return s;
    else if (dec && !inc)
      return -s;
    return '0;
  endfunction

endpackage

// File: rtl/debounce_tecla.sv
// One active-low key: 2-flop synchroniser plus stability counter.
// pressed is high while the debounced level is low.
module debounce_tecla #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pressed
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic          deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      deb <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = ~deb;

endmodule

// File: rtl/controle_posicao_objeto.sv
// Per-frame object position scheduler: debounced keys, v_sync
// frame detect and a 4-state FSM applying one clamped step per frame.
module controle_posicao_objeto
  import vga_pkg::*;
#(
  parameter int X_INIT     = 304,
  parameter int Y_INIT     = 224,
  parameter int DEB_CYCLES = 250000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           v_sync,
  input  logic [3:0]     KEY,
  input  logic [2:0]     SW,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           frame_tick,
  output logic           moving
);

  localparam logic signed [X_W:0] XMAX_S = (X_W + 1)'(X_MAX);
  localparam logic signed [Y_W:0] YMAX_S = (Y_W + 1)'(Y_MAX);

  logic [3:0] pressed;

  for (genvar i = 0; i < 4; i++) begin : g_key
    debounce_tecla #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key    (KEY[i]),
      .pressed(pressed[i])
    );
  end

  logic vs_s1;
  logic vs_s2;
  logic vs_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
      moving     <= 1'b0;
    end else begin
      vs_s1      <= v_sync;
      vs_s2      <= vs_s1;
      vs_d       <= vs_s2;
      frame_tick <= vs_d & ~vs_s2;
      moving     <= |pressed;
    end
  end

  fsm_t       state;
  logic [3:0] keys_lat;
  logic [3:0] step_lat;

  logic signed [4:0]   dx;
  logic signed [4:0]   dy;
  logic signed [X_W:0] nx;
  logic signed [Y_W:0] ny;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;

  always_comb begin
    dx = axis_step(keys_lat[0], keys_lat[1], step_lat);
    dy = axis_step(keys_lat[2], keys_lat[3], step_lat);
    nx = signed'({1'b0, pos_x}) + {{(X_W - 4){dx[4]}}, dx};
    ny = signed'({1'b0, pos_y}) + {{(Y_W - 4){dy[4]}}, dy};
    if (nx < 0)
      cx = '0;
    else if (nx > XMAX_S)
      cx = X_W'(X_MAX);
    else
      cx = nx[X_W-1:0];
    if (ny < 0)
      cy = '0;
    else if (ny > YMAX_S)
      cy = Y_W'(Y_MAX);
    else
      cy = ny[Y_W-1:0];
  end

  // Ticks arriving outside IDLE are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      keys_lat <= '0;
      step_lat <= '0;
      pos_x    <= X_W'(X_INIT);
      pos_y    <= Y_W'(Y_INIT);
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick) begin
            keys_lat <= pressed;
            step_lat <= {1'b0, SW} + 4'd1;
            state    <= LATCH;
          end
        end
        LATCH: begin
          pos_x <= cx;
          state <= UPD_X;
        end
        UPD_X: begin
          pos_y <= cy;
          state <= UPD_Y;
        end
        UPD_Y: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
